// File: rtl/adder_share_arb.sv
// adder_share_arb: one pipelined (WIDTH+1)-bit adder shared by NREQ requesters.
// A round-robin arbiter launches at most one operand pair per cycle, and each
// sum comes back exactly LAT cycles later with a one-hot strobe that names
// the requester it belongs to.
module adder_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH:0]          rsp_q,
    output logic                    busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = IDXW + 1;

    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic             grant_valid;
    logic [IDXW-1:0]  grant_idx;
    logic [CW-1:0]    cand;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   grant_sum;

    logic [LAT-1:0]   valid_q, valid_d;
    logic [IDXW-1:0]  idx_q [LAT];
    logic [IDXW-1:0]  idx_d [LAT];
    logic [WIDTH:0]   sum_q [LAT];
    logic [WIDTH:0]   sum_d [LAT];
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;

    // Round-robin search starting at ptr; the first valid requester wins the adder.
    always_comb begin
        req_ready   = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (!reset && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, ptr_q} + CW'(k);
                if (cand >= CW'(NREQ)) begin
                    cand = cand - CW'(NREQ);
                end
                if (!grant_valid && req_valid[cand[IDXW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[IDXW-1:0];
                end
            end
        end
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Select the winner's operands and form the full-width sum so no carry is lost.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDXW'(i)) begin
                op_a = req_a[i*WIDTH +: WIDTH];
                op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
        grant_sum = {1'b0, op_a} + {1'b0, op_b};
    end

    // Advance the pointer past the requester just served so nobody starves.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);
        end
    end

    // Shift the pipeline; tag and sum only load with a valid op so the last stage keeps the previous result.
    always_comb begin
        valid_d[0] = grant_valid;
        idx_d[0]   = grant_valid ? grant_idx : idx_q[0];
        sum_d[0]   = grant_valid ? grant_sum : sum_q[0];
        for (int s = 1; s < LAT; s++) begin
            valid_d[s] = valid_q[s-1];
            idx_d[s]   = valid_q[s-1] ? idx_q[s-1] : idx_q[s];
            sum_d[s]   = valid_q[s-1] ? sum_q[s-1] : sum_q[s];
        end
        rsp_valid_d = '0;
        if (valid_d[LAT-1]) begin
            rsp_valid_d[idx_d[LAT-1]] = 1'b1;
        end
    end

    // State registers; reset throws away anything in flight and returns the pointer to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            valid_q     <= '0;
            rsp_valid_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                idx_q[s] <= '0;
                sum_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            rsp_valid_q <= rsp_valid_d;
            for (int s = 0; s < LAT; s++) begin
                idx_q[s] <= idx_d[s];
                sum_q[s] <= sum_d[s];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = sum_q[LAT-1];
    assign busy      = |valid_q;

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one pipelined (WIDTH+1)-bit adder among NREQ requesters.
- Round-robin arbiter picks at most one request per cycle and launches its operands into the adder pipeline.
- Returns each sum, tagged by requester, a fixed LAT cycles later.
- Sits between client blocks and the shared adder datapath; it replaces the per-client adder instances.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width in bits
- LAT, 2, adder pipeline depth: cycles from accept to result (1..4)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- hold  input  1  when 1, no new grants; in-flight operations still drain
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester grant; combinational, one-hot or zero
- req_a  input  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a
- rsp_valid  output  NREQ  one-hot result strobe, registered
- rsp_q  output  WIDTH+1  result sum, registered
- busy  output  1  1 while any operation is in flight

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - rsp_valid=0, rsp_q=0, busy=0.
  - Round-robin pointer ptr=0.
  - All pipeline stage valids=0.
  - req_ready=0 while reset is high.
- Arbitration (combinational):
  - When hold=0 and reset=0, req_ready[i]=1 for the first i with req_valid[i]=1.
  - The search order is ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - At most one bit of req_ready is set. If no req_valid bit is set, req_ready=0.
  - A transfer occurs when req_valid[i] & req_ready[i] are both 1.
- Requester rules:
  - A requester holds req_valid and its operands stable until req_ready is seen.
  - Dropping req_valid before the grant is allowed.
  - The arbiter never depends on req_ready feeding back into req_valid.
- Pointer update:
  - On a transfer from requester g, ptr <= (g+1) mod NREQ.
  - Otherwise ptr is unchanged.
  - This guarantees starvation freedom: each waiting requester is granted within NREQ transfers.
- Pipeline:
  - Stage 0 captures valid, the requester index (clog2(NREQ) bits, minimum 1) and sum = {1'b0,a} + {1'b0,b}. The sum is full-width WIDTH+1, with no overflow loss.
  - Stages 1..LAT-1 are shift registers. The addition may be split across stages, but the result must be identical.
  - Transfer in cycle T gives rsp_valid[g]=1 and rsp_q=sum during cycle T+LAT, for exactly one cycle.
  - Throughput is 1 per cycle. There is no backpressure on responses: requesters must accept every result.
- Outputs when idle:
  - rsp_valid=0.
  - rsp_q holds its last value; it is not cleared except by reset.
- busy:
  - busy is 1 if any stage valid is 1.
  - The combinational grant of the current cycle is not included in busy.
- hold:
  - hold blocks new grants only.
  - Operations already in flight complete on schedule.
  - ptr does not change while hold=1.
- Reset mid-operation:
  - All in-flight operations are discarded.
  - No rsp_valid pulse is produced for them after reset is released.
- Simultaneous events:
  - Grant and result delivery in the same cycle are independent.
  - A requester may be granted again in the cycle its previous result returns.

Test Plan:
- Single request: NREQ=4, WIDTH=8, LAT=2. req_valid=4'b0100, a[2]=8'hFF, b[2]=8'h01 → req_ready=4'b0100 at T; rsp_valid=4'b0100, rsp_q=9'h100 at T+2; busy=1 during T+1..T+2.
- Round-robin fairness: all four valid continuously from reset (ptr=0) → grants in order 0,1,2,3,0,1 on consecutive cycles; rsp_valid follows the same order, each 2 cycles later, one result per cycle.
- Pointer skip: after a grant to requester 1, only requesters 0 and 3 are valid → requester 3 is granted first, then 0; ptr ends at 1.
- hold: four back-to-back grants, then hold=1 for 5 cycles with all requests valid → req_ready=0 during hold; in-flight results still appear at T+2; busy falls to 0; after hold=0, the grant resumes at the saved ptr.
- Reset mid-flight: grant at T, reset=1 at T+1 → no rsp_valid at T+2; rsp_q=0, ptr=0, busy=0 after reset.
- Boundary sums and latency: a=8'h00, b=8'h00 → 9'h000; a=8'h80, b=8'h80 → 9'h100; repeat with LAT=1 and LAT=4 → result latency is exactly LAT cycles.
